// File: rtl/cell_processor_if.sv
// Cell-processor bus: two 3x3 RGB cells, a user constant pixel and an opcode in, one pixel out.
// The master modport drives cells/opcode; the slave modport is the processing core.
interface cell_processor_if;
   localparam int unsigned PIX_W  = 24;
   localparam int unsigned CELL_N = 9;
   localparam int unsigned CELL_W = PIX_W * CELL_N;

   logic [CELL_W-1:0] cellA;
   logic [CELL_W-1:0] cellB;
   logic [PIX_W-1:0]  userInputA;
   logic [2:0]        opcode;
   logic [PIX_W-1:0]  processedPixel;

   modport master (output cellA, output cellB, output userInputA, output opcode,
                   input  processedPixel);
   modport slave  (input  cellA, input  cellB, input  userInputA, input  opcode,
                   output processedPixel);
endinterface

// File: rtl/cell_processor.sv
// Two-stage per-pixel RGB processing core (ADD/SUB/ADDC/SUBC/AVG/INV/BLUR/DIFF), 1 result/clock.
// Define CELL_PROC_SATURATE_EN to clamp ADD/ADDC/SUB/SUBC instead of wrapping modulo 256.
module cell_processor (
   input  logic              clk,
   input  logic              rst,
   cell_processor_if.slave   cell_if
);
   localparam int unsigned PIX_W  = 24;
   localparam int unsigned CELL_N = 9;
   localparam int unsigned CELL_W = PIX_W * CELL_N;
   localparam int unsigned CH_W   = 8;
   localparam int unsigned CH_N   = PIX_W / CH_W;
   localparam int unsigned SUM_W  = 12;
   localparam int unsigned CTR    = 4;

   localparam logic [2:0] OP_ADD  = 3'd0;
   localparam logic [2:0] OP_SUB  = 3'd1;
   localparam logic [2:0] OP_ADDC = 3'd2;
   localparam logic [2:0] OP_SUBC = 3'd3;
   localparam logic [2:0] OP_AVG  = 3'd4;
   localparam logic [2:0] OP_INV  = 3'd5;
   localparam logic [2:0] OP_BLUR = 3'd6;
   localparam logic [2:0] OP_DIFF = 3'd7;

   logic [CELL_W-1:0] cell_a_q, cell_b_q;
   logic [PIX_W-1:0]  user_q;
   logic [2:0]        opcode_q;
   logic [PIX_W-1:0]  pix_q, pix_d;

   function automatic logic [CH_W-1:0] add8(input logic [CH_W-1:0] x, input logic [CH_W-1:0] y);
      logic [CH_W:0] s;
      s = {1'b0, x} + {1'b0, y};
`ifdef CELL_PROC_SATURATE_EN
      add8 = s[CH_W] ? {CH_W{1'b1}} : s[CH_W-1:0];
`else
      add8 = s[CH_W-1:0];
`endif
   endfunction

   // Bit CH_W of the extended difference is the borrow.
   function automatic logic [CH_W-1:0] sub8(input logic [CH_W-1:0] x, input logic [CH_W-1:0] y);
      logic [CH_W:0] s;
      s = {1'b0, x} - {1'b0, y};
`ifdef CELL_PROC_SATURATE_EN
      sub8 = s[CH_W] ? '0 : s[CH_W-1:0];
`else
      sub8 = s[CH_W-1:0];
`endif
   endfunction

   // Stage 1: register all inputs.
   always_ff @(posedge clk) begin
      if (!rst) begin
         cell_a_q <= '0;
         cell_b_q <= '0;
         user_q   <= '0;
         opcode_q <= OP_ADD;
      end else begin
         cell_a_q <= cell_if.cellA;
         cell_b_q <= cell_if.cellB;
         user_q   <= cell_if.userInputA;
         opcode_q <= cell_if.opcode;
      end
   end

   // Stage 2 datapath: per-channel operation on the centre pixels.
   always_comb begin
      logic [CH_W-1:0]  a_ch, b_ch, u_ch, r_ch;
      logic [CH_W:0]    avg_sum;
      logic [SUM_W-1:0] blur_sum;
      pix_d = '0;
      for (int unsigned c = 0; c < CH_N; c++) begin
         a_ch     = cell_a_q[CTR*PIX_W + c*CH_W +: CH_W];
         b_ch     = cell_b_q[CTR*PIX_W + c*CH_W +: CH_W];
         u_ch     = user_q[c*CH_W +: CH_W];
         avg_sum  = {1'b0, a_ch} + {1'b0, b_ch};
         blur_sum = '0;
         for (int unsigned k = 0; k < CELL_N; k++) begin
            blur_sum = blur_sum + SUM_W'(cell_a_q[k*PIX_W + c*CH_W +: CH_W]);
         end
         unique case (opcode_q)
            OP_ADD:  r_ch = add8(a_ch, b_ch);
            OP_SUB:  r_ch = sub8(a_ch, b_ch);
            OP_ADDC: r_ch = add8(a_ch, u_ch);
            OP_SUBC: r_ch = sub8(a_ch, u_ch);
            OP_AVG:  r_ch = avg_sum[CH_W:1];
            OP_INV:  r_ch = ~a_ch;
            OP_BLUR: r_ch = CH_W'(blur_sum / SUM_W'(CELL_N));
            OP_DIFF: r_ch = (a_ch >= b_ch) ? (a_ch - b_ch) : (b_ch - a_ch);
            default: r_ch = '0;
         endcase
         pix_d[c*CH_W +: CH_W] = r_ch;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) pix_q <= '0;
      else      pix_q <= pix_d;
   end

   assign cell_if.processedPixel = pix_q;
endmodule

// File: tb/tb_cell_processor.sv
// Scoreboard bench for cell_processor: driver pushes expected pixels, monitor checks 2 edges later.
module tb_cell_processor;
   logic clk;
   logic rst;
   cell_processor_if bus ();

   cell_processor dut (.clk(clk), .rst(rst), .cell_if(bus.slave));

   typedef struct {
      logic [23:0] exp;
      string       name;
   } sb_t;

   sb_t sb_q[$];
   int  checks = 0;
   int  passed = 0;
   bit  mon_on = 1'b1;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   // Independent integer model of one opcode on the whole pixel.
   function automatic logic [23:0] golden(input logic [215:0] a, input logic [215:0] b,
                                          input logic [23:0] u, input logic [2:0] op);
      logic [23:0] r;
      int av, bv, uv, s, v;
      r = '0;
      for (int c = 0; c < 3; c++) begin
         av = int'(a[96 + 8*c +: 8]);
         bv = int'(b[96 + 8*c +: 8]);
         uv = int'(u[8*c +: 8]);
         s  = 0;
         for (int k = 0; k < 9; k++) s += int'(a[24*k + 8*c +: 8]);
         case (op)
            3'd0: v = av + bv;
            3'd1: v = av - bv;
            3'd2: v = av + uv;
            3'd3: v = av - uv;
            3'd4: v = (av + bv) / 2;
            3'd5: v = 255 - av;
            3'd6: v = s / 9;
            default: v = (av > bv) ? av - bv : bv - av;
         endcase
`ifdef CELL_PROC_SATURATE_EN
         if (v > 255) v = 255;
         if (v < 0)   v = 0;
`else
         v = v & 255;
`endif
         r[8*c +: 8] = 8'(v);
      end
      return r;
   endfunction

   function automatic logic [215:0] rand_cell();
      logic [215:0] x;
      for (int k = 0; k < 9; k++) x[24*k +: 24] = 24'($urandom);
      return x;
   endfunction

   task automatic drive_cells(input logic r, input logic [215:0] a, input logic [215:0] b,
                              input logic [23:0] u, input logic [2:0] op,
                              input logic [23:0] exp, input string name);
      sb_t e;
      @(negedge clk);
      rst            = r;
      bus.cellA      = a;
      bus.cellB      = b;
      bus.userInputA = u;
      bus.opcode     = op;
      e.exp  = r ? exp : 24'h000000;
      e.name = name;
      sb_q.push_back(e);
   endtask

   task automatic drive_dir(input logic [23:0] a4, input logic [23:0] b4, input logic [23:0] u,
                            input logic [2:0] op, input logic [23:0] exp, input string name);
      logic [215:0] a, b;
      a = rand_cell();
      b = rand_cell();
      a[96 +: 24] = a4;
      b[96 +: 24] = b4;
      drive_cells(1'b1, a, b, u, op, exp, name);
   endtask

   // Monitor: entry popped at edge N is the stage-1 content; it is due after edge N+1.
   initial begin
      logic [23:0] pend_exp, exp_out;
      string       pend_name, cur_name;
      sb_t         e;
      pend_exp  = 24'h000000;
      pend_name = "reset";
      forever begin
         @(posedge clk);
         exp_out  = rst ? pend_exp : 24'h000000;
         cur_name = rst ? pend_name : "reset";
         if (sb_q.size() > 0) begin
            e         = sb_q.pop_front();
            pend_exp  = e.exp;
            pend_name = e.name;
         end else begin
            pend_exp  = 24'h000000;
            pend_name = "idle";
         end
         #1;
         if (mon_on) begin
            checks++;
            if (bus.processedPixel !== exp_out)
               $display("FAIL %s: got %h expected %h at %0t", cur_name, bus.processedPixel,
                        exp_out, $time);
            else
               passed++;
         end
      end
   end

   initial begin
      logic [215:0] a, b;
      logic [23:0]  u;
      logic [2:0]   op;
      rst            = 1'b0;
      bus.cellA      = '0;
      bus.cellB      = '0;
      bus.userInputA = '0;
      bus.opcode     = '0;

      // Reset with random inputs held for two edges.
      for (int i = 0; i < 2; i++)
         drive_cells(1'b0, rand_cell(), rand_cell(), 24'($urandom), 3'($urandom), 24'h0, "reset");

      drive_dir(24'h102030, 24'h010203, 24'h0, 3'd0, 24'h112233, "add");
`ifdef CELL_PROC_SATURATE_EN
      drive_dir(24'hF0F0F0, 24'h202020, 24'h0, 3'd0, 24'hFFFFFF, "add_ovf");
      drive_dir(24'h10FF80, 24'h200010, 24'h0, 3'd1, 24'h00FF70, "sub_unf");
      drive_dir(24'h10FF80, 24'h0, 24'h200010, 3'd3, 24'h00FF70, "subc");
      drive_dir(24'hF0F0F0, 24'h0, 24'h202020, 3'd2, 24'hFFFFFF, "addc_ovf");
`else
      drive_dir(24'hF0F0F0, 24'h202020, 24'h0, 3'd0, 24'h101010, "add_ovf");
      drive_dir(24'h10FF80, 24'h200010, 24'h0, 3'd1, 24'hF0FF70, "sub_unf");
      drive_dir(24'h10FF80, 24'h0, 24'h200010, 3'd3, 24'hF0FF70, "subc");
      drive_dir(24'hF0F0F0, 24'h0, 24'h202020, 3'd2, 24'h101010, "addc_ovf");
`endif
      drive_dir(24'h00FF0F, 24'h123456, 24'h0, 3'd5, 24'hFF00F0, "inv");
      drive_dir(24'hFF0001, 24'h01FF02, 24'h0, 3'd4, 24'h807F01, "avg");
      drive_dir(24'hFF0001, 24'h01FF02, 24'h0, 3'd7, 24'hFEFF01, "diff");

      a = '0;
      for (int k = 0; k < 9; k++) a[24*k +: 24] = {8'(9 + k), 8'hFF, (k == 0) ? 8'd8 : 8'd0};
      drive_cells(1'b1, a, rand_cell(), 24'($urandom), 3'd6, 24'h0DFF00, "blur");

      // Streaming: new cells and opcode every clock, reset pulse mid-stream.
      for (int i = 0; i < 100; i++) begin
         a  = rand_cell();
         b  = rand_cell();
         u  = 24'($urandom);
         op = 3'(i % 8);
         if (i >= 40 && i < 42)
            drive_cells(1'b0, a, b, u, op, 24'h0, "stream_rst");
         else
            drive_cells(1'b1, a, b, u, op, golden(a, b, u, op), "stream");
      end

      for (int i = 0; i < 3; i++)
         drive_cells(1'b1, '0, '0, '0, 3'd0, 24'h000000, "drain");
      @(posedge clk);
      @(posedge clk);
      #2;
      mon_on = 1'b0;
      if (sb_q.size() != 0) begin
         checks++;
         $display("FAIL scoreboard_drain: got %0d entries expected 0", sb_q.size());
      end
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
